// File: rtl/chroma_key_pipe_if.sv
// Pixel, config and statistics signals of chroma_key_pipe, grouped for port connection.
// The master modport drives the pixel/config inputs; the slave modport is the keyer.
interface chroma_key_pipe_if #(
    parameter int unsigned CW    = 10,
    parameter int unsigned CNT_W = 20
);
    logic             iCfgWr;
    logic [1:0]       iCfgAddr;
    logic [CW-1:0]    iCfgData;
    logic             iValid;
    logic             iSOF;
    logic [CW-1:0]    iRed;
    logic [CW-1:0]    iGreen;
    logic [CW-1:0]    iBlue;
    logic [CW-1:0]    imVGA_R;
    logic [CW-1:0]    imVGA_G;
    logic [CW-1:0]    imVGA_B;
    logic             oValid;
    logic             oSOF;
    logic [CW-1:0]    gsRed;
    logic [CW-1:0]    gsGreen;
    logic [CW-1:0]    gsBlue;
    logic [CNT_W-1:0] oKeyCount;
    logic             oKeyCountValid;

    modport master (
        output iCfgWr, iCfgAddr, iCfgData, iValid, iSOF, iRed, iGreen, iBlue,
               imVGA_R, imVGA_G, imVGA_B,
        input  oValid, oSOF, gsRed, gsGreen, gsBlue, oKeyCount, oKeyCountValid
    );

    modport slave (
        input  iCfgWr, iCfgAddr, iCfgData, iValid, iSOF, iRed, iGreen, iBlue,
               imVGA_R, imVGA_G, imVGA_B,
        output oValid, oSOF, gsRed, gsGreen, gsBlue, oKeyCount, oKeyCountValid
    );
endinterface

// File: rtl/chroma_key_pipe.sv
// Two-stage chroma keyer: keyed foreground pixels are replaced by the background pixel,
// keyed pixels are counted per frame. Define CHROMA_SPILL_EN to clamp key-colour spill.
module chroma_key_pipe #(
    parameter int unsigned CW       = 10,
    parameter int unsigned TH_K_DEF = 400,
    parameter int unsigned TH_A_DEF = 100,
    parameter int unsigned TH_B_DEF = 100,
    parameter int unsigned CNT_W    = 20
) (
    input logic               iCLK,
    input logic               iRST,
    chroma_key_pipe_if.slave  bus
);
    localparam logic [CW-1:0]    TH_K_RST = CW'(TH_K_DEF);
    localparam logic [CW-1:0]    TH_A_RST = CW'(TH_A_DEF);
    localparam logic [CW-1:0]    TH_B_RST = CW'(TH_B_DEF);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Pending set is written by config; active set is what the key decision uses.
    logic [CW-1:0] r_pend_k, r_pend_a, r_pend_b;
    logic          r_pend_en, r_pend_kb;
    logic [CW-1:0] r_act_k, r_act_a, r_act_b;
    logic          r_act_en, r_act_kb;

    logic w_sof_in;
    assign w_sof_in = bus.iValid & bus.iSOF;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_pend_k  <= TH_K_RST;
            r_pend_a  <= TH_A_RST;
            r_pend_b  <= TH_B_RST;
            r_pend_en <= 1'b1;
            r_pend_kb <= 1'b0;
            r_act_k   <= TH_K_RST;
            r_act_a   <= TH_A_RST;
            r_act_b   <= TH_B_RST;
            r_act_en  <= 1'b1;
            r_act_kb  <= 1'b0;
        end else begin
            if (w_sof_in) begin
                r_act_k  <= r_pend_k;
                r_act_a  <= r_pend_a;
                r_act_b  <= r_pend_b;
                r_act_en <= r_pend_en;
                r_act_kb <= r_pend_kb;
            end
            if (bus.iCfgWr) begin
                unique case (bus.iCfgAddr)
                    2'd0: r_pend_k <= bus.iCfgData;
                    2'd1: r_pend_a <= bus.iCfgData;
                    2'd2: r_pend_b <= bus.iCfgData;
                    2'd3: begin
                        r_pend_en <= bus.iCfgData[0];
                        r_pend_kb <= bus.iCfgData[1];
                    end
                endcase
            end
        end
    end

    // The SOF pixel already sees the set that the active registers are about to load.
    logic [CW-1:0]        w_th_k, w_th_a, w_th_b;
    logic                 w_en, w_kb;
    logic [CW-1:0]        w_k, w_a, w_b;
    logic signed [CW:0]   w_da, w_db;
    logic                 w_key;

    always_comb begin
        w_th_k = w_sof_in ? r_pend_k  : r_act_k;
        w_th_a = w_sof_in ? r_pend_a  : r_act_a;
        w_th_b = w_sof_in ? r_pend_b  : r_act_b;
        w_en   = w_sof_in ? r_pend_en : r_act_en;
        w_kb   = w_sof_in ? r_pend_kb : r_act_kb;
        w_k    = w_kb ? bus.iBlue  : bus.iGreen;
        w_a    = bus.iRed;
        w_b    = w_kb ? bus.iGreen : bus.iBlue;
        w_da   = $signed({1'b0, w_k}) - $signed({1'b0, w_a});
        w_db   = $signed({1'b0, w_k}) - $signed({1'b0, w_b});
        w_key  = w_en & (w_k > w_th_k)
                      & (w_da > $signed({1'b0, w_th_a}))
                      & (w_db > $signed({1'b0, w_th_b}));
    end

    logic          r_s1_valid, r_s1_sof, r_s1_key;
    logic [CW-1:0] r_s1_fg_r, r_s1_fg_g, r_s1_fg_b;
    logic [CW-1:0] r_s1_bg_r, r_s1_bg_g, r_s1_bg_b;
`ifdef CHROMA_SPILL_EN
    logic [CW-1:0] w_max;
    logic [CW-1:0] r_s1_max;
    logic          r_s1_en, r_s1_kb;
    assign w_max = (w_a > w_b) ? w_a : w_b;
`endif

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_s1_valid <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_key   <= 1'b0;
            r_s1_fg_r  <= '0;
            r_s1_fg_g  <= '0;
            r_s1_fg_b  <= '0;
            r_s1_bg_r  <= '0;
            r_s1_bg_g  <= '0;
            r_s1_bg_b  <= '0;
`ifdef CHROMA_SPILL_EN
            r_s1_max   <= '0;
            r_s1_en    <= 1'b0;
            r_s1_kb    <= 1'b0;
`endif
        end else begin
            r_s1_valid <= bus.iValid;
            r_s1_sof   <= w_sof_in;
            r_s1_key   <= w_key;
            r_s1_fg_r  <= bus.iRed;
            r_s1_fg_g  <= bus.iGreen;
            r_s1_fg_b  <= bus.iBlue;
            r_s1_bg_r  <= bus.imVGA_R;
            r_s1_bg_g  <= bus.imVGA_G;
            r_s1_bg_b  <= bus.imVGA_B;
`ifdef CHROMA_SPILL_EN
            r_s1_max   <= w_max;
            r_s1_en    <= w_en;
            r_s1_kb    <= w_kb;
`endif
        end
    end

    logic [CW-1:0] w_gs_r, w_gs_g, w_gs_b;

    always_comb begin
        w_gs_r = r_s1_key ? r_s1_bg_r : r_s1_fg_r;
        w_gs_g = r_s1_key ? r_s1_bg_g : r_s1_fg_g;
        w_gs_b = r_s1_key ? r_s1_bg_b : r_s1_fg_b;
`ifdef CHROMA_SPILL_EN
        if (r_s1_valid && r_s1_en && !r_s1_key) begin
            if (r_s1_kb && (r_s1_fg_b > r_s1_max)) w_gs_b = r_s1_max;
            if (!r_s1_kb && (r_s1_fg_g > r_s1_max)) w_gs_g = r_s1_max;
        end
`endif
    end

    logic             r_s2_valid, r_s2_sof;
    logic [CW-1:0]    r_gs_r, r_gs_g, r_gs_b;
    logic [CNT_W-1:0] r_cnt, r_key_count;
    logic             r_cnt_valid;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_s2_valid <= 1'b0;
            r_s2_sof   <= 1'b0;
            r_gs_r     <= '0;
            r_gs_g     <= '0;
            r_gs_b     <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_sof   <= r_s1_sof;
            r_gs_r     <= w_gs_r;
            r_gs_g     <= w_gs_g;
            r_gs_b     <= w_gs_b;
        end
    end

    // Count report updates on the same edge that presents the SOF pixel on the outputs.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_cnt       <= '0;
            r_key_count <= '0;
            r_cnt_valid <= 1'b0;
        end else if (r_s1_valid && r_s1_sof) begin
            r_key_count <= r_cnt;
            r_cnt_valid <= 1'b1;
            r_cnt       <= CNT_W'(r_s1_key);
        end else begin
            r_cnt_valid <= 1'b0;
            if (r_s1_valid && r_s1_key && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.oValid         = r_s2_valid;
    assign bus.oSOF           = r_s2_sof;
    assign bus.gsRed          = r_gs_r;
    assign bus.gsGreen        = r_gs_g;
    assign bus.gsBlue         = r_gs_b;
    assign bus.oKeyCount      = r_key_count;
    assign bus.oKeyCountValid = r_cnt_valid;
endmodule

// File: tb/tb_chroma_key_pipe.sv
// Bench for chroma_key_pipe: directed steps plus random traffic against a frame-level
// reference model of keying, config timing and per-frame counting.
module tb_chroma_key_pipe;
    localparam int CW = 10;
    localparam int CNT_W = 20;
    localparam int TH_K_D = 400;
    localparam int TH_A_D = 100;
    localparam int TH_B_D = 100;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    chroma_key_pipe_if #(.CW(CW), .CNT_W(CNT_W)) bus ();

    chroma_key_pipe #(
        .CW(CW), .TH_K_DEF(TH_K_D), .TH_A_DEF(TH_A_D), .TH_B_DEF(TH_B_D), .CNT_W(CNT_W)
    ) dut (
        .iCLK(clk),
        .iRST(rst),
        .bus (bus)
    );

    typedef struct {
        bit v;
        bit sof;
        int r;
        int g;
        int b;
        bit cv;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail = 0;
    int   m_pk, m_pa, m_pb, m_ak, m_aa, m_ab;
    bit   m_pen, m_pkb, m_aen, m_akb;
    int   m_cnt, m_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pk = TH_K_D; m_pa = TH_A_D; m_pb = TH_B_D; m_pen = 1'b1; m_pkb = 1'b0;
        m_ak = TH_K_D; m_aa = TH_A_D; m_ab = TH_B_D; m_aen = 1'b1; m_akb = 1'b0;
        m_cnt = 0; m_last = 0;
        q.delete();
    endtask

    function automatic int imax(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // One pixel clock: drive inputs, predict the result, compare the pixel from 2 cycles back.
    task automatic cycle(input bit v, input bit sof, input int r, input int g, input int b,
                         input int br, input int bgr, input int bb,
                         input bit wr, input int addr, input int data);
        exp_t e;
        bit   key;
        int   kc, oa, ob;
        @(negedge clk);
        bus.iValid = v; bus.iSOF = sof;
        bus.iRed = CW'(r); bus.iGreen = CW'(g); bus.iBlue = CW'(b);
        bus.imVGA_R = CW'(br); bus.imVGA_G = CW'(bgr); bus.imVGA_B = CW'(bb);
        bus.iCfgWr = wr; bus.iCfgAddr = 2'(addr); bus.iCfgData = CW'(data);

        if (v && sof) begin
            m_ak = m_pk; m_aa = m_pa; m_ab = m_pb; m_aen = m_pen; m_akb = m_pkb;
        end
        kc = m_akb ? b : g;
        oa = r;
        ob = m_akb ? g : b;
        key = v && m_aen && (kc > m_ak) && ((kc - oa) > m_aa) && ((kc - ob) > m_ab);
        e.v = v;
        e.sof = v && sof;
        if (key) begin
            e.r = br; e.g = bgr; e.b = bb;
        end else begin
            e.r = r; e.g = g; e.b = b;
`ifdef CHROMA_SPILL_EN
            if (v && m_aen && kc > imax(oa, ob)) begin
                if (m_akb) e.b = imax(oa, ob);
                else e.g = imax(oa, ob);
            end
`endif
        end
        if (v && sof) begin
            m_last = m_cnt;
            e.cv = 1'b1;
            m_cnt = key ? 1 : 0;
        end else begin
            e.cv = 1'b0;
            if (key && m_cnt < CMAX) m_cnt++;
        end
        e.cnt = m_last;
        if (wr) begin
            case (addr)
                0: m_pk = data;
                1: m_pa = data;
                2: m_pb = data;
                default: begin m_pen = data[0]; m_pkb = data[1]; end
            endcase
        end
        q.push_back(e);

        @(posedge clk);
        #1;
        if (q.size() >= 2) begin
            e = q.pop_front();
            chk("oValid", 32'(bus.oValid), 32'(e.v));
            chk("oSOF", 32'(bus.oSOF), 32'(e.sof));
            chk("oKeyCountValid", 32'(bus.oKeyCountValid), 32'(e.cv));
            chk("oKeyCount", 32'(bus.oKeyCount), e.cnt);
            if (e.v) begin
                chk("gsRed", 32'(bus.gsRed), e.r);
                chk("gsGreen", 32'(bus.gsGreen), e.g);
                chk("gsBlue", 32'(bus.gsBlue), e.b);
            end
        end
    endtask

    task automatic pix(input bit sof, input int r, input int g, input int b,
                       input int br, input int bgr, input int bb);
        cycle(1'b1, sof, r, g, b, br, bgr, bb, 1'b0, 0, 0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 0, 0);
    endtask

    task automatic cfg(input int addr, input int data);
        cycle(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b1, addr, data);
    endtask

    task automatic chk_rgb(input string tag, input int r, input int g, input int b);
        chk({tag, "_R"}, 32'(bus.gsRed), r);
        chk({tag, "_G"}, 32'(bus.gsGreen), g);
        chk({tag, "_B"}, 32'(bus.gsBlue), b);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_oValid"}, 32'(bus.oValid), 0);
        chk({tag, "_oSOF"}, 32'(bus.oSOF), 0);
        chk_rgb(tag, 0, 0, 0);
        chk({tag, "_oKeyCount"}, 32'(bus.oKeyCount), 0);
        chk({tag, "_oKeyCountValid"}, 32'(bus.oKeyCountValid), 0);
    endtask

    initial begin
        bus.iCfgWr = 1'b0; bus.iCfgAddr = '0; bus.iCfgData = '0;
        bus.iValid = 1'b0; bus.iSOF = 1'b0;
        bus.iRed = '0; bus.iGreen = '0; bus.iBlue = '0;
        bus.imVGA_R = '0; bus.imVGA_G = '0; bus.imVGA_B = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Default thresholds: strong green keys to background.
        pix(1'b1, 50, 600, 50, 111, 222, 333);
        idle();
        chk("dflt_oValid", 32'(bus.oValid), 1);
        chk_rgb("dflt", 111, 222, 333);

        // Negative K-A must not wrap into a large positive margin.
        pix(1'b0, 900, 500, 50, 1, 2, 3);
        idle();
        chk_rgb("nowrap", 900, 500, 50);

        // Strict threshold boundary on the key channel.
        pix(1'b0, 300, 400, 300, 1, 2, 3);
        idle();
        chk_rgb("thk_eq", 300, 400, 300);
        pix(1'b0, 300, 401, 300, 4, 5, 6);
        idle();
        chk_rgb("thk_gt", 4, 5, 6);

        // A mid-frame threshold write waits for the next SOF.
        cfg(0, 700);
        pix(1'b0, 50, 600, 50, 7, 8, 9);
        idle();
        chk_rgb("pend", 7, 8, 9);
        pix(1'b1, 50, 600, 50, 7, 8, 9);
        idle();
        chk_rgb("sof_apply", 50, 600, 50);

        // Frame of 8 valid pixels, 5 keyed, then SOF reports 5.
        cfg(0, 400);
        pix(1'b1, 0, 0, 0, 1, 1, 1);
        pix(1'b0, 50, 600, 50, 1, 1, 1);
        pix(1'b0, 50, 600, 50, 1, 1, 1);
        pix(1'b0, 900, 500, 50, 1, 1, 1);
        idle();
        pix(1'b0, 50, 600, 50, 1, 1, 1);
        pix(1'b0, 50, 600, 50, 1, 1, 1);
        pix(1'b0, 10, 20, 30, 1, 1, 1);
        pix(1'b0, 50, 600, 50, 1, 1, 1);
        pix(1'b1, 0, 0, 0, 1, 1, 1);
        idle();
        chk("cnt_frame", 32'(bus.oKeyCount), 5);
        chk("cnt_pulse", 32'(bus.oKeyCountValid), 1);
        chk("cnt_sof", 32'(bus.oSOF), 1);
        idle();
        chk("cnt_pulse_end", 32'(bus.oKeyCountValid), 0);

        // Spill: non-keyed greenish pixel.
        pix(1'b0, 200, 350, 150, 1, 1, 1);
        idle();
`ifdef CHROMA_SPILL_EN
        chk_rgb("spill", 200, 200, 150);
`else
        chk_rgb("spill", 200, 350, 150);
`endif

        // Disabled frame passes foreground and reports zero keyed pixels.
        cfg(3, 0);
        pix(1'b1, 50, 600, 50, 1, 1, 1);
        pix(1'b0, 50, 600, 50, 1, 1, 1);
        pix(1'b0, 50, 600, 50, 1, 1, 1);
        idle();
        chk_rgb("disabled", 50, 600, 50);
        cfg(3, 1);
        pix(1'b1, 0, 0, 0, 1, 1, 1);
        idle();
        chk("dis_cnt", 32'(bus.oKeyCount), 0);
        chk("dis_pulse", 32'(bus.oKeyCountValid), 1);

        // Blue-key mode, then random traffic with occasional reconfiguration.
        cfg(3, 3);
        pix(1'b1, 50, 50, 700, 9, 9, 9);
        pix(1'b0, 50, 700, 50, 3, 3, 3);
        idle();
        chk_rgb("blue_mode", 50, 700, 50);
        for (int i = 0; i < 1500; i++) begin
            bit v, sof, wr;
            int addr, data;
            v = ($urandom_range(0, 99) < 85);
            sof = v && ($urandom_range(0, 39) == 0);
            wr = ($urandom_range(0, 29) == 0);
            addr = $urandom_range(0, 3);
            if (addr == 3) data = ($urandom_range(0, 1) << 1) | ($urandom_range(0, 4) != 0);
            else data = $urandom_range(0, 600);
            cycle(v, sof, $urandom_range(0, 1023), $urandom_range(0, 1023),
                  $urandom_range(0, 1023), $urandom_range(0, 1023),
                  $urandom_range(0, 1023), $urandom_range(0, 1023), wr, addr, data);
        end

        // Asynchronous reset mid-frame with non-default settings active.
        cfg(3, 1);
        cfg(0, 700);
        pix(1'b1, 50, 600, 50, 1, 1, 1);
        pix(1'b0, 50, 600, 50, 1, 1, 1);
        @(negedge clk);
        bus.iValid = 1'b0; bus.iSOF = 1'b0; bus.iCfgWr = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pix(1'b0, 300, 401, 300, 7, 8, 9);
        idle();
        chk_rgb("rst_dflt", 7, 8, 9);
        chk("rst_cnt", 32'(bus.oKeyCount), 0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
